// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block memory port between the I-cache and D-cache.
// One transaction in flight at a time. All memory-side and requester-side outputs are registered.
//   state  | meaning
//   IDLE   | sample requests, grant one on the next edge
//   BUSY_I | I transaction presented to memory, waiting for mem_ready
//   BUSY_D | D transaction presented to memory, waiting for mem_ready
//   DONE   | ready pulse to the finished requester, requests ignored
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        grant
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2, DONE = 2'd3} state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [1:0]        grant_q, grant_d;

    logic i_act, d_act, pick_i, pick_d;

    assign i_act  = i_read | i_write;
    assign d_act  = d_read | d_write;
    // On a tie the side that did not own the port last time wins.
    assign pick_i = i_act & (~d_act | last_d_q);
    assign pick_d = d_act & (~i_act | ~last_d_q);

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            grant_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            grant_q     <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_i)      state_d = BUSY_I;
                else if (pick_d) state_d = BUSY_D;
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d_d    = last_d_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        grant_d     = grant_q;
        case (state_q)
            IDLE: begin
                if (pick_i) begin
                    mem_addr_d  = i_addr;
                    mem_wdata_d = i_wdata;
                    mem_write_d = i_write;
                    mem_read_d  = i_read & ~i_write;
                    grant_d     = 2'b01;
                    last_d_d    = 1'b0;
                end else if (pick_d) begin
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_write_d = d_write;
                    mem_read_d  = d_read & ~d_write;
                    grant_d     = 2'b10;
                    last_d_d    = 1'b1;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    if (mem_read_q) i_rdata_d = mem_rdata;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    i_ready_d   = 1'b1;
                    grant_d     = 2'b00;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    if (mem_read_q) d_rdata_d = mem_rdata;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    d_ready_d   = 1'b1;
                    grant_d     = 2'b00;
                end
            end
            default: ;
        endcase
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign grant     = grant_q;
endmodule
